// File: rtl/axi4_burst_arb.sv
// axi4_burst_arb: shares one DDR command port between the frame writer and
// frame reader engines. Picks one burst at a time, holds it on the command
// channel until accepted, then tracks write-data completion and the number
// of read bursts still in flight.
module axi4_burst_arb #(
    parameter int C_ADDR_W     = 32,
    parameter int C_MAX_RD_OUT = 2,
    parameter int C_STARVE_MAX = 64
) (
    input  logic                axi_clk,
    input  logic                axi_resetn,
    input  logic                wr_req,
    input  logic [C_ADDR_W-1:0] wr_addr,
    input  logic [7:0]          wr_len,
    output logic                wr_gnt,
    input  logic                rd_req,
    input  logic [C_ADDR_W-1:0] rd_addr,
    input  logic [7:0]          rd_len,
    input  logic                rd_urgent,
    output logic                rd_gnt,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                cmd_we,
    output logic [C_ADDR_W-1:0] cmd_addr,
    output logic [7:0]          cmd_len,
    input  logic                wdata_fire,
    input  logic                wdata_last,
    input  logic                rdata_fire,
    input  logic                rdata_last,
    output logic [2:0]          rd_out,
    output logic                busy,
    output logic                err
);

    localparam logic [7:0] C_STARVE_LIM = 8'(C_STARVE_MAX);
    localparam logic [2:0] C_RD_LIM     = 3'(C_MAX_RD_OUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WDATA} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_cmd_valid;
    logic                  r_cmd_we;
    logic [C_ADDR_W-1:0]   r_cmd_addr;
    logic [7:0]            r_cmd_len;
    logic                  r_wr_gnt;
    logic                  r_rd_gnt;
    logic                  r_last_wr;     // 1: last granted requester was the writer
    logic [2:0]            r_rd_out;
    logic                  r_err;

    logic                  w_wr_elig;
    logic                  w_rd_elig;
    logic                  w_sel_valid;
    logic                  w_sel_we;
    logic                  w_load;
    logic                  w_hs;
    logic                  w_rd_done;
    logic                  w_rd_dec_ok;
    logic                  w_wr_done;
    logic [1:0]            w_req;         // index 0 = write, 1 = read
    logic [1:0]            w_req_hs;
    logic [1:0]            w_starved;

    assign w_hs      = r_cmd_valid & cmd_ready;
    assign w_rd_done = rdata_fire & rdata_last;
    assign w_wr_done = wdata_fire & wdata_last;
    assign w_rd_dec_ok = w_rd_done & (r_rd_out != 3'd0);

    // A requester is masked during its own grant cycle so a still-high req
    // is not granted a second time.
    assign w_wr_elig = wr_req & ~r_wr_gnt;
    assign w_rd_elig = rd_req & ~r_rd_gnt & (r_rd_out < C_RD_LIM);

    assign w_req    = {rd_req, wr_req};
    assign w_req_hs = {w_hs & ~r_cmd_we, w_hs & r_cmd_we};

    // Per-requester wait counters: count while waiting, saturate, clear when idle or served.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_starve
            logic [7:0] r_cnt;
            always_ff @(posedge axi_clk or negedge axi_resetn) begin
                if (!axi_resetn) begin
                    r_cnt <= 8'd0;
                end else if (!w_req[gi] || w_req_hs[gi]) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt != C_STARVE_LIM) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
            assign w_starved[gi] = (r_cnt == C_STARVE_LIM);
        end
    endgenerate

    // Winner selection: starvation, then read urgency, then single requester, then round-robin.
    always_comb begin
        w_sel_valid = w_wr_elig | w_rd_elig;
        w_sel_we    = 1'b0;
        if (w_starved[1] && w_rd_elig) begin
            w_sel_we = 1'b0;
        end else if (w_starved[0] && w_wr_elig) begin
            w_sel_we = 1'b1;
        end else if (rd_urgent && w_rd_elig) begin
            w_sel_we = 1'b0;
        end else if (w_wr_elig && !w_rd_elig) begin
            w_sel_we = 1'b1;
        end else if (w_wr_elig && w_rd_elig) begin
            w_sel_we = ~r_last_wr;
        end
    end

    // State register.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_sel_valid) w_state_next = S_ISSUE;
            S_ISSUE: if (w_hs) w_state_next = r_cmd_we ? S_WDATA : S_IDLE;
            S_WDATA: if (w_wr_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy   = (r_state != S_IDLE);
        w_load = (r_state == S_IDLE) && w_sel_valid;
    end

    // Command channel, grant pulses and round-robin pointer.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_len   <= 8'd0;
            r_wr_gnt    <= 1'b0;
            r_rd_gnt    <= 1'b0;
            r_last_wr   <= 1'b1;
        end else begin
            r_wr_gnt <= w_hs & r_cmd_we;
            r_rd_gnt <= w_hs & ~r_cmd_we;
            if (w_load) begin
                r_cmd_valid <= 1'b1;
                r_cmd_we    <= w_sel_we;
                r_cmd_addr  <= w_sel_we ? wr_addr : rd_addr;
                r_cmd_len   <= w_sel_we ? wr_len : rd_len;
            end else if (w_hs) begin
                r_cmd_valid <= 1'b0;
                r_last_wr   <= r_cmd_we;
            end
        end
    end

    // Outstanding read bursts and sticky protocol error.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_rd_out <= 3'd0;
            r_err    <= 1'b0;
        end else begin
            case ({w_req_hs[1], w_rd_dec_ok})
                2'b10:   r_rd_out <= r_rd_out + 3'd1;
                2'b01:   r_rd_out <= r_rd_out - 3'd1;
                default: r_rd_out <= r_rd_out;
            endcase
            if ((w_rd_done && r_rd_out == 3'd0) || (w_wr_done && r_state != S_WDATA)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wr_gnt    = r_wr_gnt;
    assign rd_gnt    = r_rd_gnt;
    assign cmd_valid = r_cmd_valid;
    assign cmd_we    = r_cmd_we;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_len   = r_cmd_len;
    assign rd_out    = r_rd_out;
    assign err       = r_err;

endmodule
